// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with config handshake, run control and match counting.
// Optional feature: define SEQ_DET_CTRL_OVERLAP_SEL_EN to honour cfg_overlap; otherwise detection always overlaps.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [PAT_W-1:0]    pat_q, pat_n;
  logic [CNT_W-1:0]    lim_q, lim_n;
  logic [PAT_W-1:0]    hist, hist_n;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [CNT_W-1:0]    cnt_n;
  logic                q_n;

  logic                cfg_fire;
  logic [PAT_W-1:0]    hist_shift;
  logic [FILL_W-1:0]   fill_inc;
  logic [CNT_W-1:0]    cnt_inc;
  logic                hit;
  logic                eff_ovl;

`ifdef SEQ_DET_CTRL_OVERLAP_SEL_EN
  logic ovl_q, ovl_n;
  assign eff_ovl = ovl_q;
`else
  logic unused_cfg_overlap;
  assign unused_cfg_overlap = cfg_overlap;
  assign eff_ovl = 1'b1;
`endif

  assign cfg_ready  = (state != RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign hist_shift = {hist[PAT_W-2:0], x};
  assign fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
  assign cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
  // stop has priority over a coinciding match, so it masks the hit outright
  assign hit        = (state == RUN) && x_valid && !stop &&
                      (fill_inc == FILL_FULL) && (hist_shift == pat_q);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_n = state;
    pat_n   = pat_q;
    lim_n   = lim_q;
    hist_n  = hist;
    fill_n  = fill;
    cnt_n   = match_cnt;
    q_n     = 1'b0;
`ifdef SEQ_DET_CTRL_OVERLAP_SEL_EN
    ovl_n   = ovl_q;
`endif

    if (cfg_fire) begin
      pat_n   = cfg_pattern;
      lim_n   = cfg_limit;
`ifdef SEQ_DET_CTRL_OVERLAP_SEL_EN
      ovl_n   = cfg_overlap;
`endif
      state_n = ARMED;
    end

    unique case (state)
      IDLE: ;
      ARMED, DONE: begin
        if (start) begin
          state_n = RUN;
          cnt_n   = '0;
          hist_n  = '0;
          fill_n  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (x_valid) begin
          hist_n = hist_shift;
          fill_n = fill_inc;
          if (hit) begin
            q_n   = 1'b1;
            cnt_n = cnt_inc;
            if (!eff_ovl) fill_n = '0;
            if ((lim_q != '0) && (cnt_inc == lim_q)) state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      lim_q     <= '0;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      q         <= 1'b0;
`ifdef SEQ_DET_CTRL_OVERLAP_SEL_EN
      ovl_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      pat_q     <= pat_n;
      lim_q     <= lim_n;
      hist      <= hist_n;
      fill      <= fill_n;
      match_cnt <= cnt_n;
      q         <= q_n;
`ifdef SEQ_DET_CTRL_OVERLAP_SEL_EN
      ovl_q     <= ovl_n;
`endif
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl; expected q pulses are queued per driven bit.
module tb_seq_det_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             stop;
  logic             x;
  logic             x_valid;
  logic             q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .cfg_limit  (cfg_limit),
    .start      (start),
    .stop       (stop),
    .x          (x),
    .x_valid    (x_valid),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of serial data; the expected q for the following cycle is queued then popped after the edge.
  task automatic step(input logic xi, input logic xvi, input logic stpi, input bit eq, input string tag);
    bit e;
    x       = xi;
    x_valid = xvi;
    stop    = stpi;
    exp_q.push_back(eq);
    tick();
    e = exp_q.pop_front();
    check(tag, {31'd0, q}, {31'd0, e});
    x_valid = 1'b0;
    stop    = 1'b0;
    x       = 1'b0;
  endtask

  task automatic config_cycle(input logic [PAT_W-1:0] p, input logic ov, input logic [CNT_W-1:0] lim,
                              input logic st);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_overlap = ov;
    cfg_limit   = lim;
    start       = st;
    tick();
    cfg_valid   = 1'b0;
    start       = 1'b0;
  endtask

  task automatic start_cycle();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [6:0]  s7;
    logic [9:0]  s10;
    bit          ovl_sel;
    int          exp_cnt_novl;

`ifdef SEQ_DET_CTRL_OVERLAP_SEL_EN
    ovl_sel = 1'b1;
`else
    ovl_sel = 1'b0;
`endif

    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0; cfg_limit = '0;
    start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;

    // Reset held two cycles
    tick(); tick();
    check("rst_q",         {31'd0, q},         32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_match_cnt", {24'd0, match_cnt}, 32'd0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b1;

    // start in IDLE is ignored
    start_cycle();
    check("idle_start_ignored", {31'd0, busy}, 32'd0);

    // Overlapping detection of 1101 in 1101101
    config_cycle(4'b1101, 1'b1, 8'd0, 1'b0);
    check("armed_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("armed_busy",      {31'd0, busy},      32'd0);
    start_cycle();
    check("run_busy",      {31'd0, busy},      32'd1);
    check("run_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    s7 = 7'b1101101;
    for (int i = 6; i >= 0; i--)
      step(s7[i], 1'b1, 1'b0, (i == 3) || (i == 0), "ovl_q");
    step(1'b0, 1'b0, 1'b0, 1'b0, "ovl_idle_q");
    check("ovl_match_cnt", {24'd0, match_cnt}, 32'd2);
    check("ovl_busy",      {31'd0, busy},      32'd1);

    // stop returns to IDLE; match_cnt holds
    step(1'b0, 1'b0, 1'b1, 1'b0, "stop_q");
    check("stop_busy",      {31'd0, busy},      32'd0);
    check("stop_cnt_held",  {24'd0, match_cnt}, 32'd2);

    // Non-overlapping request, config and start in the same cycle from ARMED
    config_cycle(4'b0000, 1'b1, 8'd0, 1'b0);
    config_cycle(4'b1101, 1'b0, 8'd0, 1'b1);
    check("novl_busy",      {31'd0, busy},      32'd1);
    check("novl_cnt_clear", {24'd0, match_cnt}, 32'd0);
    for (int i = 6; i >= 0; i--)
      step(s7[i], 1'b1, 1'b0, (i == 3) || (i == 0 && !ovl_sel), "novl_q");
    exp_cnt_novl = ovl_sel ? 1 : 2;
    check("novl_match_cnt", {24'd0, match_cnt}, exp_cnt_novl);
    step(1'b0, 1'b0, 1'b1, 1'b0, "novl_stop_q");

    // limit = 2 on 1101101101
    config_cycle(4'b1101, 1'b1, 8'd2, 1'b0);
    start_cycle();
    s10 = 10'b1101101101;
    for (int i = 9; i >= 3; i--)
      step(s10[i], 1'b1, 1'b0, (i == 6) || (i == 3), "lim_q");
    check("lim_done",      {31'd0, done},      32'd1);
    check("lim_busy",      {31'd0, busy},      32'd0);
    check("lim_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    for (int i = 2; i >= 0; i--)
      step(s10[i], 1'b1, 1'b0, 1'b0, "lim_after_q");
    check("lim_cnt_held", {24'd0, match_cnt}, 32'd2);
    check("lim_done_held", {31'd0, done},     32'd1);

    // From DONE: restart unlimited, stop coinciding with completing bit
    config_cycle(4'b1101, 1'b1, 8'd0, 1'b1);
    check("restart_cnt_clear", {24'd0, match_cnt}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "stopm_q");
    step(1'b1, 1'b1, 1'b0, 1'b0, "stopm_q");
    step(1'b0, 1'b1, 1'b0, 1'b0, "stopm_q");
    step(1'b1, 1'b1, 1'b1, 1'b0, "stopm_final_q");
    step(1'b0, 1'b0, 1'b0, 1'b0, "stopm_after_q");
    check("stopm_cnt",       {24'd0, match_cnt}, 32'd0);
    check("stopm_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("stopm_busy",      {31'd0, busy},      32'd0);
    check("stopm_done",      {31'd0, done},      32'd0);

    // x_valid gap is ignored
    config_cycle(4'b1101, 1'b1, 8'd0, 1'b0);
    start_cycle();
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_q");
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap_q");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_q");
    step(1'b0, 1'b1, 1'b0, 1'b0, "gap_q");
    step(1'b1, 1'b1, 1'b0, 1'b1, "gap_last_q");
    check("gap_cnt", {24'd0, match_cnt}, 32'd1);

    // Reset mid-run on what would be a completing bit
    step(1'b1, 1'b1, 1'b0, 1'b0, "mr_q");
    step(1'b0, 1'b1, 1'b0, 1'b0, "mr_q");
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, "mr_rst_q");
    check("mr_busy",      {31'd0, busy},      32'd0);
    check("mr_cnt",       {24'd0, match_cnt}, 32'd0);
    check("mr_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, "mr_after_q");
    start_cycle();
    check("mr_idle_start_ignored", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL provide parameter PAT_W, default 4, detected pattern length in bits (2..8).
REQ-002 SHALL provide parameter CNT_W, default 8, match counter and limit width.
REQ-003 SHALL provide the following ports: clk  in  1  sole clock, all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 cfg_valid  in  1  config offer; cfg_ready  out  1  config accept; transfer when both high.
REQ-006 cfg_pattern  in  PAT_W  target pattern, MSB = oldest bit.
REQ-007 cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 cfg_limit  in  CNT_W  match count that ends a run; 0 = unlimited.
REQ-009 start  in  1  begin run; stop  in  1  abort run.
REQ-010 x  in  1  serial data bit; x_valid  in  1  x is sampled only when high.
REQ-011 q  out  1  registered one-cycle match pulse; busy  out  1  high in RUN; done  out  1  high in DONE; match_cnt  out  CNT_W  matches in current or last run.

Function
REQ-012 FSM states SHALL be IDLE, ARMED, RUN, DONE.
REQ-013 cfg_ready SHALL be 1 in IDLE, ARMED, DONE and 0 in RUN.
REQ-014 Accepted config SHALL latch pattern/overlap/limit and move to ARMED from any of IDLE, ARMED, DONE.
REQ-015 start in ARMED or DONE SHALL enter RUN next cycle, clearing match_cnt, history register and fill count; start in IDLE or RUN SHALL be ignored.
REQ-016 cfg handshake and start in the same cycle SHALL apply the new config, then enter RUN.
REQ-017 In RUN, each cycle with x_valid=1 SHALL shift x into a PAT_W history register and increment a fill count saturating at PAT_W; x_valid=0 cycles SHALL change nothing.
REQ-018 A match SHALL occur when x_valid=1, fill count (including current bit) = PAT_W and history including current bit equals the latched pattern.
REQ-019 q SHALL be 1 exactly in the cycle after the match-sampling edge, else 0; q SHALL be 0 outside RUN.
REQ-020 On match, overlap=1 SHALL keep history/fill; overlap=0 SHALL clear fill to 0.
REQ-021 On match, match_cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-022 If limit!=0 and the incremented count equals limit, FSM SHALL enter DONE next cycle; no further matches counted.
REQ-023 stop in RUN SHALL go to IDLE next cycle; stop coinciding with a match SHALL win: no q, no count increment.
REQ-024 match_cnt SHALL hold its value in IDLE, ARMED, DONE until the next start or reset.
REQ-025 done SHALL remain 1 while in DONE.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, q=0, busy=0, done=0, match_cnt=0, history/fill=0, latched config=0, cfg_ready=1 after that edge.
REQ-027 Reset mid-RUN SHALL discard partial history; no q pulse SHALL follow.

Configuration
REQ-028 Macro SEQ_DET_CTRL_OVERLAP_SEL_EN defined: cfg_overlap SHALL be latched and honoured per REQ-020.
REQ-029 Macro undefined: cfg_overlap SHALL be ignored and detection SHALL always be overlapping; port remains present.

Verification
REQ-030 Reset: hold rst=0 two cycles -> q=0, busy=0, done=0, match_cnt=0, cfg_ready=1.
REQ-031 Config 1101, overlap=1, limit=0, start, x=1,1,0,1,1,0,1 (x_valid=1) -> q pulses after bits 4 and 7, match_cnt=2, busy=1.
REQ-032 Same stream, overlap=0 with macro defined -> single q after bit 4, match_cnt=1; macro undefined -> match_cnt=2.
REQ-033 limit=2, stream 1101101101 -> done=1 after second match, busy=0, match_cnt holds 2, third pattern gives no q.
REQ-034 Stream 110 then stop=1 in same cycle as final 1 -> no q, match_cnt=0, state IDLE (cfg_ready=1, busy=0).
REQ-035 Stream 1,(x_valid=0,x=0),1,0,1 -> gap ignored, one q after last bit, match_cnt=1.
